// File: rtl/writeback.sv
// Final pipeline stage: extracts load data, selects the register-file write value,
// and keeps the forwarding register, retired-instruction counter and sticky load-fault capture.
module writeback #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_from_memory,
  input  logic [31:0]          result_from_memory,
  input  logic [2:0]           funct3_from_memory,
  input  logic [4:0]           rd_from_memory,
  input  logic                 write_reg_from_memory,
  input  logic                 select_from_memory,
  input  logic [31:0]          out_from_memory_dcache,
  input  logic                 clear_fault,
  output logic                 reg_write_en,
  output logic [4:0]           reg_write_addr,
  output logic [31:0]          reg_write_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [31:0]          fwd_data,
  output logic [INSTRET_W-1:0] instret,
  output logic                 load_fault,
  output logic [31:0]          fault_addr
);

  logic [1:0]  byteOff;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;
  logic        loadErr;
  logic        err;

  logic                 fwdValid_q, fwdValid_d;
  logic [4:0]           fwdRd_q, fwdRd_d;
  logic [31:0]          fwdData_q, fwdData_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 loadFault_q, loadFault_d;
  logic [31:0]          faultAddr_q, faultAddr_d;

  assign byteOff = result_from_memory[1:0];

  // Lane selection is little-endian; the halfword lane is chosen by the upper offset bit.
  always_comb begin
    loadByte = out_from_memory_dcache[7:0];
    case (byteOff)
      2'd0: loadByte = out_from_memory_dcache[7:0];
      2'd1: loadByte = out_from_memory_dcache[15:8];
      2'd2: loadByte = out_from_memory_dcache[23:16];
      2'd3: loadByte = out_from_memory_dcache[31:24];
      default: loadByte = out_from_memory_dcache[7:0];
    endcase
    loadHalf = byteOff[1] ? out_from_memory_dcache[31:16] : out_from_memory_dcache[15:0];
  end

  always_comb begin
    loadData = 32'd0;
    loadErr  = 1'b0;
    case (funct3_from_memory)
      3'b000: loadData = {{24{loadByte[7]}}, loadByte};
      3'b001: begin
        loadData = {{16{loadHalf[15]}}, loadHalf};
        loadErr  = byteOff[0];
      end
      3'b010: begin
        loadData = out_from_memory_dcache;
        loadErr  = (byteOff != 2'b00);
      end
      3'b100: loadData = {24'd0, loadByte};
      3'b101: begin
        loadData = {16'd0, loadHalf};
        loadErr  = byteOff[0];
      end
      default: loadErr = 1'b1;
    endcase
  end

  // An ALU-path instruction can never fault, whatever funct3 happens to hold.
  assign err = select_from_memory & loadErr;

  always_comb begin
    reg_write_addr = rd_from_memory;
    reg_write_data = 32'd0;
    if (!err) begin
      reg_write_data = select_from_memory ? loadData : result_from_memory;
    end
    reg_write_en = valid_from_memory & write_reg_from_memory & (rd_from_memory != 5'd0)
                   & ~err & ~rst;
  end

  always_comb begin
    fwdValid_d  = reg_write_en;
    fwdRd_d     = fwdRd_q;
    fwdData_d   = fwdData_q;
    instret_d   = instret_q;
    loadFault_d = loadFault_q;
    faultAddr_d = faultAddr_q;
    if (reg_write_en) begin
      fwdRd_d   = reg_write_addr;
      fwdData_d = reg_write_data;
    end
    if (valid_from_memory && !err) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
    // A fresh fault beats a simultaneous clear, so the new address is never lost.
    if (valid_from_memory && err && (!loadFault_q || clear_fault)) begin
      loadFault_d = 1'b1;
      faultAddr_d = result_from_memory;
    end else if (clear_fault) begin
      loadFault_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwdValid_q  <= 1'b0;
      fwdRd_q     <= 5'd0;
      fwdData_q   <= 32'd0;
      instret_q   <= '0;
      loadFault_q <= 1'b0;
      faultAddr_q <= 32'd0;
    end else begin
      fwdValid_q  <= fwdValid_d;
      fwdRd_q     <= fwdRd_d;
      fwdData_q   <= fwdData_d;
      instret_q   <= instret_d;
      loadFault_q <= loadFault_d;
      faultAddr_q <= faultAddr_d;
    end
  end

  assign fwd_valid  = fwdValid_q;
  assign fwd_rd     = fwdRd_q;
  assign fwd_data   = fwdData_q;
  assign instret    = instret_q;
  assign load_fault = loadFault_q;
  assign fault_addr = faultAddr_q;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: a behavioural model queues expected outputs per cycle,
// a monitor pops and compares them; a narrow-counter instance exercises counter wrap.
module tb_writeback;

  logic        clk;
  logic        rst;
  logic        valid_from_memory;
  logic [31:0] result_from_memory;
  logic [2:0]  funct3_from_memory;
  logic [4:0]  rd_from_memory;
  logic        write_reg_from_memory;
  logic        select_from_memory;
  logic [31:0] out_from_memory_dcache;
  logic        clear_fault;

  logic        reg_write_en, sReg_write_en;
  logic [4:0]  reg_write_addr, sReg_write_addr;
  logic [31:0] reg_write_data, sReg_write_data;
  logic        fwd_valid, sFwd_valid;
  logic [4:0]  fwd_rd, sFwd_rd;
  logic [31:0] fwd_data, sFwd_data;
  logic [63:0] instret;
  logic [3:0]  sInstret;
  logic        load_fault, sLoad_fault;
  logic [31:0] fault_addr, sFault_addr;

  writeback #(.INSTRET_W(64)) dut (
    .clk(clk), .rst(rst),
    .valid_from_memory(valid_from_memory), .result_from_memory(result_from_memory),
    .funct3_from_memory(funct3_from_memory), .rd_from_memory(rd_from_memory),
    .write_reg_from_memory(write_reg_from_memory), .select_from_memory(select_from_memory),
    .out_from_memory_dcache(out_from_memory_dcache), .clear_fault(clear_fault),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret), .load_fault(load_fault), .fault_addr(fault_addr)
  );

  writeback #(.INSTRET_W(4)) dutSmall (
    .clk(clk), .rst(rst),
    .valid_from_memory(valid_from_memory), .result_from_memory(result_from_memory),
    .funct3_from_memory(funct3_from_memory), .rd_from_memory(rd_from_memory),
    .write_reg_from_memory(write_reg_from_memory), .select_from_memory(select_from_memory),
    .out_from_memory_dcache(out_from_memory_dcache), .clear_fault(clear_fault),
    .reg_write_en(sReg_write_en), .reg_write_addr(sReg_write_addr), .reg_write_data(sReg_write_data),
    .fwd_valid(sFwd_valid), .fwd_rd(sFwd_rd), .fwd_data(sFwd_data),
    .instret(sInstret), .load_fault(sLoad_fault), .fault_addr(sFault_addr)
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fdata;
    logic [63:0] ir;
    logic        lf;
    logic [31:0] fa;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  bit        mFv;
  bit [4:0]  mFrd;
  bit [31:0] mFdata;
  bit [63:0] mIr;
  bit        mLf;
  bit [31:0] mFa;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: extraction by shifting/masking the word, signs by arithmetic offset.
  task automatic modelComb(input bit v, input bit [31:0] res, input bit [2:0] f3, input bit sel,
                           input bit [31:0] word, output bit err, output bit [31:0] data);
    int unsigned off;
    bit [31:0] piece;
    off = res % 4;
    err = 1'b0;
    data = res;
    if (sel) begin
      case (f3)
        3'd0, 3'd4: begin
          piece = (word >> (8 * off)) & 32'hFF;
          data = (f3 == 3'd0 && piece >= 128) ? piece + 32'hFFFF_FF00 : piece;
        end
        3'd1, 3'd5: begin
          if (off % 2 != 0) err = 1'b1;
          piece = (word >> (16 * (off / 2))) & 32'hFFFF;
          data = (f3 == 3'd1 && piece >= 32768) ? piece + 32'hFFFF_0000 : piece;
        end
        3'd2: begin
          if (off != 0) err = 1'b1;
          data = word;
        end
        default: err = 1'b1;
      endcase
    end
    if (err) data = 32'd0;
    if (!v) err = 1'b0;
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit [31:0] res, input bit [2:0] f3,
                               input bit [4:0] rd, input bit wr, input bit sel,
                               input bit [31:0] word, input bit clr);
    expT e;
    bit err, combErr;
    bit [31:0] data;
    rst = r;
    valid_from_memory = v;
    result_from_memory = res;
    funct3_from_memory = f3;
    rd_from_memory = rd;
    write_reg_from_memory = wr;
    select_from_memory = sel;
    out_from_memory_dcache = word;
    clear_fault = clr;
    modelComb(1'b1, res, f3, sel, word, combErr, data);
    err = v && combErr;
    e.en = !r && v && wr && rd != 0 && !combErr;
    e.addr = rd;
    e.data = data;
    e.fv = mFv; e.frd = mFrd; e.fdata = mFdata; e.ir = mIr; e.lf = mLf; e.fa = mFa;
    expQ.push_back(e);
    if (r) begin
      mFv = 0; mFrd = 0; mFdata = 0; mIr = 0; mLf = 0; mFa = 0;
    end else begin
      mFv = e.en;
      if (e.en) begin
        mFrd = rd;
        mFdata = data;
      end
      if (v && !err) mIr = mIr + 1;
      if (err && (!mLf || clr)) begin
        mLf = 1;
        mFa = res;
      end else if (clr) begin
        mLf = 0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("en", 64'(reg_write_en), 64'(e.en));
        checkOutput("addr", 64'(reg_write_addr), 64'(e.addr));
        checkOutput("data", 64'(reg_write_data), 64'(e.data));
        checkOutput("fwd_valid", 64'(fwd_valid), 64'(e.fv));
        checkOutput("fwd_rd", 64'(fwd_rd), 64'(e.frd));
        checkOutput("fwd_data", 64'(fwd_data), 64'(e.fdata));
        checkOutput("instret", instret, e.ir);
        checkOutput("load_fault", 64'(load_fault), 64'(e.lf));
        checkOutput("fault_addr", 64'(fault_addr), 64'(e.fa));
        checkOutput("small_en", 64'(sReg_write_en), 64'(e.en));
        checkOutput("small_addr", 64'(sReg_write_addr), 64'(e.addr));
        checkOutput("small_data", 64'(sReg_write_data), 64'(e.data));
        checkOutput("small_fwd_valid", 64'(sFwd_valid), 64'(e.fv));
        checkOutput("small_fwd_rd", 64'(sFwd_rd), 64'(e.frd));
        checkOutput("small_fwd_data", 64'(sFwd_data), 64'(e.fdata));
        checkOutput("small_instret_wrap", 64'(sInstret), 64'(e.ir[3:0]));
        checkOutput("small_load_fault", 64'(sLoad_fault), 64'(e.lf));
        checkOutput("small_fault_addr", 64'(sFault_addr), 64'(e.fa));
      end
    end
  end

  initial begin
    rst = 1'b1;
    valid_from_memory = 0; result_from_memory = 0; funct3_from_memory = 0;
    rd_from_memory = 0; write_reg_from_memory = 0; select_from_memory = 0;
    out_from_memory_dcache = 0; clear_fault = 0;
    mFv = 0; mFrd = 0; mFdata = 0; mIr = 0; mLf = 0; mFa = 0;
    repeat (2) @(posedge clk);
    #2;

    // Byte, halfword and word loads from 0x80FF7F01
    applyStimulus(0, 1, 32'h1003, 3'd0, 5'd5, 1, 1, 32'h80FF7F01, 0);
    applyStimulus(0, 1, 32'h1003, 3'd4, 5'd5, 1, 1, 32'h80FF7F01, 0);
    applyStimulus(0, 1, 32'h1002, 3'd1, 5'd6, 1, 1, 32'h80FF7F01, 0);
    applyStimulus(0, 1, 32'h1002, 3'd5, 5'd6, 1, 1, 32'h80FF7F01, 0);
    applyStimulus(0, 1, 32'h1000, 3'd2, 5'd8, 1, 1, 32'h80FF7F01, 0);
    // Fault capture, hold, clear, and clear-with-fault
    applyStimulus(0, 1, 32'h2001, 3'd1, 5'd9, 1, 1, 32'h80FF7F01, 0);
    applyStimulus(0, 1, 32'h3002, 3'd2, 5'd9, 1, 1, 32'h80FF7F01, 0);
    applyStimulus(0, 0, 32'h0, 3'd0, 5'd0, 0, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h4003, 3'd2, 5'd9, 1, 1, 32'h80FF7F01, 1);
    // ALU path and x0
    applyStimulus(0, 1, 32'hDEADBEEF, 3'd7, 5'd0, 1, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hDEADBEEF, 3'd7, 5'd7, 1, 0, 32'h0, 0);
    // Ten valid instructions with three bubbles after a reset
    applyStimulus(1, 1, 32'h10, 3'd0, 5'd3, 1, 0, 32'h0, 0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, !(i == 2 || i == 6 || i == 10), 32'(i * 4), 3'd2, 5'(i + 1), 1, 1,
                    32'(i * 17), 0);
    end
    // Reset mid-stream with a writing instruction present
    applyStimulus(1, 1, 32'h55, 3'd0, 5'd3, 1, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 3'd0, 5'd0, 0, 0, 32'h0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, $urandom,
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                    $urandom_range(0, 9) == 0);
    end
    applyStimulus(0, 0, 32'h0, 3'd0, 5'd0, 0, 0, 32'h0, 0);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
    checks++;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0 records left", expQ.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
